// File: rtl/mux_pkg.sv
// Shared constants and helpers for the parametrised channel mux/arbiter.
//   MODE_FIXED / MODE_RR : values of the mode input
//   clog2()              : select/index width for a channel count
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2, minimum 1 so a 2-channel mux still gets a 1-bit select.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : per-channel request vector
//   last  : index of the most recent winner; search starts at last+1
//   grant : one-hot grant (all zero when no request)
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]        req,
  input  logic [clog2(NUM_CH)-1:0] last,
  output logic [NUM_CH-1:0]        grant
);

  logic w_found;

  // Walk offsets 1..NUM_CH from last, wrapping modulo NUM_CH; first requester wins.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!w_found && req[i] && (i == ((32'(last) + k) % NUM_CH))) begin
          grant[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/param_mux_arbiter.sv
// NUM_CH:1 valid/ready mux with a single registered output stage.
//   clk, rst_n            : clock, async active-low reset
//   mode                  : 0 fixed select via sel, 1 round-robin
//   sel                   : channel select (mode 0 only)
//   in_data/in_valid      : packed channel payloads and valids
//   in_ready              : combinational per-channel ready (at most one high)
//   out_data/out_ch/valid : registered output word, source channel, valid
//   out_ready             : downstream ready
module param_mux_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic              r_out_valid;
  logic [SEL_W-1:0]  r_last;

  logic              w_load_en;
  logic [NUM_CH-1:0] w_fix_grant;
  logic [NUM_CH-1:0] w_rr_grant;
  logic [NUM_CH-1:0] w_grant;
  logic              w_xfer;
  logic [SEL_W-1:0]  w_xfer_idx;
  logic [DATA_W-1:0] w_xfer_data;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req   (in_valid),
    .last  (r_last),
    .grant (w_rr_grant)
  );

  assign w_load_en = !r_out_valid || out_ready;

  // Fixed-select decode; an out-of-range sel matches no channel and grants nothing.
  always_comb begin
    w_fix_grant = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if ((32'(sel) == i) && in_valid[i]) w_fix_grant[i] = 1'b1;
    end
  end

  assign w_grant = (mode == MODE_RR) ? w_rr_grant : w_fix_grant;

  // Ready is forced low while reset is held, independent of register state.
  assign in_ready = w_grant & {NUM_CH{w_load_en}} & {NUM_CH{rst_n}};
  assign w_xfer   = |in_ready;

  // One-hot grant to index and payload (AND-OR mux).
  always_comb begin
    w_xfer_idx  = '0;
    w_xfer_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        w_xfer_idx  = SEL_W'(i);
        w_xfer_data = w_xfer_data | in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_last      <= SEL_W'(NUM_CH - 1);
    end else if (w_load_en) begin
      if (w_xfer) begin
        r_out_data  <= w_xfer_data;
        r_out_ch    <= w_xfer_idx;
        r_out_valid <= 1'b1;
        if (mode == MODE_RR) r_last <= w_xfer_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_param_mux_arbiter.sv
// Directed bench: 4-channel instance for fixed, round-robin, reset and
// backpressure behaviour; 3-channel instance for an out-of-range select.
module tb_param_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        mode = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [31:0] in_data = 32'h0;
  logic [3:0]  in_valid = 4'h0;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready = 1'b1;

  logic        mode3 = 1'b0;
  logic [1:0]  sel3 = 2'd0;
  logic [23:0] in_data3 = 24'h0;
  logic [2:0]  in_valid3 = 3'h0;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_mux_arbiter #(.NUM_CH(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  param_mux_arbiter #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check one registered output word of the 4-channel instance.
  task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] ch,
                         input logic v);
    chk({tag, ".data"},  64'(out_data),  64'(d));
    chk({tag, ".ch"},    64'(out_ch),    64'(ch));
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
  endtask

  initial begin
    // Reset held across an edge.
    step();
    chk("rst.valid", 64'(out_valid), 64'(1'b0));
    chk("rst.data",  64'(out_data),  64'(8'h00));
    chk("rst.ch",    64'(out_ch),    64'(2'd0));
    in_valid = 4'b1111;
    #1;
    chk("rst.ready", 64'(in_ready), 64'(4'b0000));
    rst_n = 1'b1;

    // Fixed select.
    mode = 1'b0; sel = 2'd2; in_data = 32'h44332211; out_ready = 1'b1;
    #1;
    chk("fix.ready2", 64'(in_ready), 64'(4'b0100));
    step();
    chk_out("fix.ch2", 8'h33, 2'd2, 1'b1);
    chk("fix.ready2b", 64'(in_ready), 64'(4'b0100));
    sel = 2'd3;
    #1;
    chk("fix.ready3", 64'(in_ready), 64'(4'b1000));
    step();
    chk_out("fix.ch3", 8'h44, 2'd3, 1'b1);

    // Reset mid-stream discards the held word immediately.
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 64'(out_valid), 64'(1'b0));
    chk("midrst.ready", 64'(in_ready),  64'(4'b0000));
    step();
    in_valid = 4'b0000;
    rst_n = 1'b1;
    step();
    chk("idle.valid1", 64'(out_valid), 64'(1'b0));
    step();
    chk("idle.valid2", 64'(out_valid), 64'(1'b0));

    // Round-robin fairness, pointer starts at 3.
    mode = 1'b1; in_valid = 4'b1111;
    #1;
    chk("rr.ready0", 64'(in_ready), 64'(4'b0001));
    step(); chk_out("rr.0", 8'h11, 2'd0, 1'b1);
    step(); chk_out("rr.1", 8'h22, 2'd1, 1'b1);
    step(); chk_out("rr.2", 8'h33, 2'd2, 1'b1);
    step(); chk_out("rr.3", 8'h44, 2'd3, 1'b1);
    step(); chk_out("rr.4", 8'h11, 2'd0, 1'b1);
    step(); chk_out("rr.5", 8'h22, 2'd1, 1'b1);

    // Backpressure with 0x22 from ch1 held.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp.ready", 64'(in_ready), 64'(4'b0000));
      step();
      chk_out("bp.hold", 8'h22, 2'd1, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 64'(in_ready), 64'(4'b0100));
    step();
    chk_out("bp.next", 8'h33, 2'd2, 1'b1);

    // Skip and wrap from a fresh pointer of 3.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    in_valid = 4'b1010;
    #1;
    chk("skip.ready1", 64'(in_ready), 64'(4'b0010));
    step(); chk_out("skip.a", 8'h22, 2'd1, 1'b1);
    chk("skip.ready3", 64'(in_ready), 64'(4'b1000));
    step(); chk_out("skip.b", 8'h44, 2'd3, 1'b1);
    step(); chk_out("skip.c", 8'h22, 2'd1, 1'b1);
    step(); chk_out("skip.d", 8'h44, 2'd3, 1'b1);
    in_valid = 4'b0001;
    #1;
    chk("wrap.ready0", 64'(in_ready), 64'(4'b0001));
    step(); chk_out("wrap.ch0", 8'h11, 2'd0, 1'b1);
    in_valid = 4'b0000;
    step(); chk_out("drain", 8'h11, 2'd0, 1'b0);

    // Out-of-range select on the 3-channel instance.
    mode3 = 1'b0; sel3 = 2'd1; in_data3 = 24'hC3B2A1; in_valid3 = 3'b111; out_ready3 = 1'b0;
    step();
    chk("inv.load_data", 64'(out_data3), 64'(8'hB2));
    chk("inv.load_valid", 64'(out_valid3), 64'(1'b1));
    sel3 = 2'd3;
    #1;
    chk("inv.ready_held", 64'(in_ready3), 64'(3'b000));
    out_ready3 = 1'b1;
    #1;
    chk("inv.ready_open", 64'(in_ready3), 64'(3'b000));
    step();
    chk("inv.valid", 64'(out_valid3), 64'(1'b0));
    chk("inv.data_hold", 64'(out_data3), 64'(8'hB2));
    chk("inv.ch_hold", 64'(out_ch3), 64'(2'd1));
    chk("inv.ready_idle", 64'(in_ready3), 64'(3'b000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_mux_arbiter.md
Name: param_mux_arbiter

Overview:
- Parametrised successor to the gate-level 4:1 mux: selects one of NUM_CH input channels, each DATA_W bits wide, onto a single registered output.
- Every input and the output use a valid/ready handshake.
- Two modes:
  - fixed select: channel chosen by `sel`
  - round-robin: fair rotating arbitration among valid channels
- Sits between multiple producers and one shared consumer, e.g. lab peripherals sharing a single display or UART path.

Parameters:
- NUM_CH, 4: number of input channels (2..16).
- DATA_W, 8: data width per channel (1..64).
- SEL_W, $clog2(NUM_CH): derived width of `sel` and `out_ch`; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel select, used only when mode = 0.
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready, combinational, at most one bit high.
- out_data  out  DATA_W  registered output data.
- out_ch  out  SEL_W  index of the channel that produced out_data.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.

Behaviour:
- **Interface:** one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- **Reset values:**
  - out_valid = 0, out_data = 0, out_ch = 0.
  - Round-robin pointer `last` = NUM_CH-1, so channel 0 has first priority.
  - All in_ready bits fall to 0 while reset is asserted.
- **Output register load:**
  - load_en = !out_valid || out_ready.
  - Single-stage pipeline: an input accepted at edge N appears on out_data/out_ch with out_valid=1 after edge N.
  - Latency 1 cycle; sustained throughput 1 transfer per cycle when out_ready stays high.
- **Grant, mode 0:**
  - grant = one-hot(sel) if sel < NUM_CH and in_valid[sel]; otherwise no grant.
  - sel >= NUM_CH: no grant and all in_ready = 0. This is not an error; no flag is raised.
- **Grant, mode 1:**
  - Search channels last+1, last+2, … modulo NUM_CH.
  - The first channel with in_valid = 1 wins. Wrap-around from NUM_CH-1 to 0 is required.
- **Ready:** in_ready[i] = grant[i] && load_en.
- **Transfer:** a transfer on channel i happens when in_valid[i] && in_ready[i].
  - out_data <= channel data, out_ch <= i, out_valid <= 1.
  - In mode 1 only, last <= i. `last` does not change on cycles with no transfer, and never changes in mode 0.
- **No grant:** when there is no grant and out_ready = 1, out_valid <= 0. out_data and out_ch hold their previous values.
- **Backpressure:** while out_valid && !out_ready, out_data, out_ch and out_valid hold stable and all in_ready = 0.
- **Simultaneous events:** out_ready = 1 together with a new grant gives back-to-back transfer with no bubble.
- **Mode/sel changes:** take effect on the same cycle's grant (combinational). A held output word is unaffected.
- **Reset mid-operation:** a pending output word is discarded. out_valid = 0 immediately (asynchronous), and `last` returns to NUM_CH-1.
- **in_valid drop:** a producer dropping in_valid before acceptance is permitted. The grant simply re-evaluates.

Decomposition:
- Package `mux_pkg`:
  - Constants MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - Function `clog2` used for SEL_W.
- Sub-module `rr_arbiter` (parameter NUM_CH):
  - Purely combinational.
  - Inputs: request vector, last pointer. Output: one-hot grant.
  - The top level holds the `last` register, the output register and the mode-0 decode.

Test Plan:
1. Reset/idle: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0 and in_ready=0000 immediately. After release with no valids -> out_valid stays 0.
2. Fixed mode: NUM_CH=4, DATA_W=8, mode=0, sel=2, in_valid=1111, in_data ch0..3 = 0x11, 0x22, 0x33, 0x44, out_ready=1:
   - in_ready=0100 every cycle.
   - Next cycle out_data=0x33, out_ch=2, out_valid=1.
   - sel=3 -> the following output is 0x44.
3. Round-robin fairness: mode=1, all four valid continuously, out_ready=1 -> out_ch sequence 0, 1, 2, 3, 0, 1 on consecutive cycles with no bubbles.
4. Round-robin skip and wrap: mode=1, last=3, in_valid=1010 -> grant ch1, then ch3, then ch1. With in_valid=0001 after a ch3 grant -> ch0 wins.
5. Backpressure: out_ready=0 for 3 cycles after out_data=0x22 loads -> out_data=0x22 and out_ch=1 held, in_ready=0000, `last` unchanged. out_ready=1 -> next channel is accepted that same cycle.
6. Invalid sel: mode=0, NUM_CH=3, sel=3, all valid -> in_ready=000. Once out_ready=1 drains any held word, out_valid=0.
